request_unit: RTL

REQUEST_UNIT -- requirements
Module: request_unit

---
 rtl/cpu_types_pkg.sv | 11 +
 rtl/request_unit_if.sv | 33 +++
 rtl/perf_counter.sv | 29 ++
 rtl/request_unit.sv | 104 ++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
// reqstate_t: request-unit FSM states, encoded in the order FETCH, DWAIT, HALTED.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// Request unit bundle: every non-clock/reset signal of request_unit.
//   ihit, dhit, dren, dwen, halt        : inputs to the unit
//   imemREN, dmemREN, dmemWEN, pcEn,
//   haltOut, instrCount, stallCount     : outputs of the unit
// Modports: ru (the unit itself), tb (whoever drives and observes it).
interface request_unit_if #(
  parameter int unsigned CNT_W = 32
);

  logic             ihit;
  logic             dhit;
  logic             dren;
  logic             dwen;
  logic             halt;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic             pcEn;
  logic             haltOut;
  logic [CNT_W-1:0] instrCount;
  logic [CNT_W-1:0] stallCount;

  modport ru (
    input  ihit, dhit, dren, dwen, halt,
    output imemREN, dmemREN, dmemWEN, pcEn, haltOut, instrCount, stallCount
  );

  modport tb (
    output ihit, dhit, dren, dwen, halt,
    input  imemREN, dmemREN, dmemWEN, pcEn, haltOut, instrCount, stallCount
  );

endinterface

// File: rtl/perf_counter.sv
// Enable-driven wrapping event counter with asynchronous active-low clear.
//   CLK     : clock
//   nRST    : asynchronous active-low clear
//   en_i    : count this edge
//   count_o : current count, wraps modulo 2^CNT_W
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/request_unit.sv
// Memory request unit: sequences instruction fetch, one outstanding data
// access, and halt, and keeps retired-instruction / data-stall counters.
//   CLK, nRST : clock, asynchronous active-low reset
//   rif       : request_unit_if.ru (hit/decode inputs, memory requests,
//               PC strobe, sticky halt, performance counters)
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  request_unit_if.ru      rif
);

  reqstate_t state_q, state_d;
  logic      dmem_ren_q, dmem_ren_d;
  logic      dmem_wen_q, dmem_wen_d;
  logic      pc_en;
  logic      stall_en;

  always_comb begin
    state_d    = state_q;
    dmem_ren_d = dmem_ren_q;
    dmem_wen_d = dmem_wen_q;
    unique case (state_q)
      FETCH: begin
        if (rif.ihit) begin
          if (rif.halt) begin
            state_d    = HALTED;
            dmem_ren_d = 1'b0;
            dmem_wen_d = 1'b0;
          end else if (rif.dren || rif.dwen) begin
            state_d    = DWAIT;
            // A store wins when the decoder flags both.
            dmem_wen_d = rif.dwen;
            dmem_ren_d = rif.dren & ~rif.dwen;
          end
        end
      end
      DWAIT: begin
        if (rif.dhit) begin
          state_d    = FETCH;
          dmem_ren_d = 1'b0;
          dmem_wen_d = 1'b0;
        end
      end
      HALTED: begin
        dmem_ren_d = 1'b0;
        dmem_wen_d = 1'b0;
      end
      default: begin
        state_d    = FETCH;
        dmem_ren_d = 1'b0;
        dmem_wen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= FETCH;
      dmem_ren_q <= 1'b0;
      dmem_wen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dmem_ren_q <= dmem_ren_d;
      dmem_wen_q <= dmem_wen_d;
    end
  end

  always_comb begin
    pc_en = ((state_q == FETCH) && rif.ihit && !rif.halt && !rif.dren && !rif.dwen)
         || ((state_q == DWAIT) && rif.dhit);
    stall_en = (state_q == DWAIT) && !rif.dhit;
  end

  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] stall_count;

  perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .CLK     (CLK),
    .nRST    (nRST),
    .en_i    (pc_en),
    .count_o (instr_count)
  );

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .nRST    (nRST),
    .en_i    (stall_en),
    .count_o (stall_count)
  );

  assign rif.imemREN    = (state_q == FETCH) || (state_q == DWAIT);
  assign rif.dmemREN    = dmem_ren_q;
  assign rif.dmemWEN    = dmem_wen_q;
  assign rif.pcEn       = pc_en;
  // Halt is sticky because HALTED only leaves on reset.
  assign rif.haltOut    = (state_q == HALTED);
  assign rif.instrCount = instr_count;
  assign rif.stallCount = stall_count;

endmodule
